oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Sprite DMA engine behind CPU register $4014.
- A CPU write of page number P halts the CPU.
- It then copies CPU-bus bytes $P00-$PFF into OAM through the PPU OAMDATA port (CPU_ADDR 3'h4). This is the same path the CPU uses for single OAMDATA writes.
- Sits upstream of the PPU, between the CPU bus arbiter and the PPU CPU-side write interface. Replaces 256 software OAMDATA stores.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer.
- OAMDATA_REG, 3'h4, PPU register index driven during write cycles.
- XFER_LEN, 256, bytes per transfer. Fixed; the index is 8 bits.

Ports:
- CLK  in  1  system clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- CPU_CE  in  1  one-CLK pulse marking a CPU cycle boundary; all state advances only when CPU_CE=1.
- CPU_ADDR  in  16  CPU bus address.
- CPU_DATA_IN  in  8  CPU write data (page number).
- CPU_wren  in  1  CPU write strobe, qualified by CPU_CE.
- CPU_HALT  out  1  CPU RDY-low/stall request.
- DMA_BUS_ADDR  out  16  source read address {page, idx}.
- DMA_BUS_RD  out  1  source read request.
- DMA_BUS_DATA_IN  in  8  source read data.
- PPU_ADDR_OUT  out  3  PPU register index.
- PPU_DATA_OUT  out  8  byte written to OAMDATA.
- PPU_WREN  out  1  PPU register write strobe.
- DMA_ACTIVE  out  1  transfer in progress (HALT through last WRITE).

Behaviour:
- Decided: one clock CLK; RESET is synchronous and active-high.
- Reset values: CPU_HALT=0, DMA_BUS_RD=0, PPU_WREN=0, DMA_ACTIVE=0, DMA_BUS_ADDR=16'h0000, PPU_ADDR_OUT=3'h0, PPU_DATA_OUT=8'h00. Internal: state=IDLE, page=0, idx=0, buf=0, parity=0.
- parity toggles on every CPU_CE while not in reset. It is 0 on the first CE after reset.
- States: IDLE, HALT, ALIGN, READ, WRITE. All transitions occur on CLK edges with CPU_CE=1.
- IDLE: on CPU_CE & CPU_wren & CPU_ADDR==DMA_REG_ADDR → latch page=CPU_DATA_IN, idx=0, go HALT. Any other address → stay in IDLE.
- HALT (1 CE): CPU_HALT=1 and DMA_ACTIVE=1 from this state until IDLE is re-entered.
  - If parity=1 at the end of HALT → go ALIGN.
  - Otherwise → go READ.
- ALIGN (1 CE): no bus activity → go READ.
- READ (1 CE): DMA_BUS_ADDR={page,idx}, DMA_BUS_RD=1. On the CE edge leaving READ, buf<=DMA_BUS_DATA_IN → go WRITE. Source data must be valid before the next CE.
- WRITE (1 CE): PPU_ADDR_OUT=OAMDATA_REG, PPU_DATA_OUT=buf, PPU_WREN=1.
  - PPU_WREN is a one-CLK pulse on the first CLK of WRITE, not held for the whole CE period. This gives exactly one OAMDATA write per byte; the PPU increments OAMADDR itself.
  - Leaving WRITE: if idx==8'hFF → IDLE, else idx<=idx+1 and go READ.
- Outside READ, DMA_BUS_RD=0. Outside the first CLK of WRITE, PPU_WREN=0. Address/data outputs hold their last values.
- Duration, counted in CE edges from the trigger to IDLE: 513 if HALT ends on even parity, 514 if odd.
- CPU_HALT is asserted on the CLK after the trigger CE edge. It deasserts on the CLK after the final WRITE CE edge.
- idx wraps 8'hFF→end. The page never increments. Page 8'hFF reads $FF00-$FFFF.
- Writes to DMA_REG_ADDR while DMA_ACTIVE=1 are ignored: no restart and no page change.
- CPU_CE held low: the FSM freezes and all outputs hold, except that PPU_WREN stays a single pulse.
- RESET mid-transfer: the next CLK returns to IDLE with all outputs at reset values. There are no further reads or writes, and the partial OAM contents are left as-is.
- RESET and a trigger on the same edge: reset wins.

Test Plan:
- Even parity, write 8'h02 to $4014; source $0200+i = i^8'h5A → 256 PPU_WREN pulses, each PPU_ADDR_OUT=3'h4, data i^8'h5A in order; CPU_HALT high for exactly 513 CE; DMA_BUS_ADDR sweeps $0200-$02FF.
- Same transfer triggered one CE later (odd parity) → CPU_HALT high for 514 CE, one ALIGN cycle with no RD/WREN, same 256-byte data.
- CPU_CE pulsed every 4 CLK, page 8'hFF → 256 writes of $FF00-$FFFF data, PPU_WREN exactly 1 CLK wide each, 513/514 CE counts unchanged.
- Assert RESET after the 100th PPU_WREN → next CLK CPU_HALT=0, DMA_ACTIVE=0, no further DMA_BUS_RD/PPU_WREN; new $4014 write then starts cleanly at idx 0.
- Write $4014=8'h03 mid-transfer of page 8'h02 → ignored, addresses stay in $02xx, total length unchanged.
- Writes to $4015 and $2014 with CPU_CE=1, and $4014 with CPU_CE=0 → no HALT, no bus activity.

Source files
------------

// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write to $4014 halts the CPU and copies page $PP00-$PPFF
// into OAM through the PPU OAMDATA register, one read/write pair per byte.
module oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter logic [2:0]  OAMDATA_REG  = 3'h4,
   parameter int unsigned XFER_LEN     = 256
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CPU_CE,
   input  logic [15:0] CPU_ADDR,
   input  logic [7:0]  CPU_DATA_IN,
   input  logic        CPU_wren,
   output logic        CPU_HALT,
   output logic [15:0] DMA_BUS_ADDR,
   output logic        DMA_BUS_RD,
   input  logic [7:0]  DMA_BUS_DATA_IN,
   output logic [2:0]  PPU_ADDR_OUT,
   output logic [7:0]  PPU_DATA_OUT,
   output logic        PPU_WREN,
   output logic        DMA_ACTIVE
);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  buf_q, buf_d;
   logic        parity_q, parity_d;
   logic [15:0] addr_q, addr_d;
   logic [2:0]  ppu_addr_q, ppu_addr_d;
   logic        wren_q, wren_d;

   always_comb begin
      state_d    = state_q;
      page_d     = page_q;
      idx_d      = idx_q;
      buf_d      = buf_q;
      parity_d   = parity_q;
      addr_d     = addr_q;
      ppu_addr_d = ppu_addr_q;
      wren_d     = 1'b0;
      if (CPU_CE) begin
         parity_d = ~parity_q;
         unique case (state_q)
            S_IDLE: begin
               if (CPU_wren && (CPU_ADDR == DMA_REG_ADDR)) begin
                  page_d  = CPU_DATA_IN;
                  idx_d   = '0;
                  state_d = S_HALT;
               end
            end
            S_HALT: begin
               if (parity_q) begin
                  state_d = S_ALIGN;
               end else begin
                  state_d = S_READ;
                  addr_d  = {page_q, idx_q};
               end
            end
            S_ALIGN: begin
               state_d = S_READ;
               addr_d  = {page_q, idx_q};
            end
            S_READ: begin
               // WREN is set only on the CE edge entering WRITE, so it lasts one CLK
               buf_d      = DMA_BUS_DATA_IN;
               ppu_addr_d = OAMDATA_REG;
               wren_d     = 1'b1;
               state_d    = S_WRITE;
            end
            S_WRITE: begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  addr_d  = {page_q, idx_q + 8'd1};
                  state_d = S_READ;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         page_q     <= '0;
         idx_q      <= '0;
         buf_q      <= '0;
         parity_q   <= 1'b0;
         addr_q     <= '0;
         ppu_addr_q <= '0;
         wren_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         page_q     <= page_d;
         idx_q      <= idx_d;
         buf_q      <= buf_d;
         parity_q   <= parity_d;
         addr_q     <= addr_d;
         ppu_addr_q <= ppu_addr_d;
         wren_q     <= wren_d;
      end
   end

   assign CPU_HALT     = (state_q != S_IDLE);
   assign DMA_ACTIVE   = (state_q != S_IDLE);
   assign DMA_BUS_RD   = (state_q == S_READ);
   assign DMA_BUS_ADDR = addr_q;
   assign PPU_ADDR_OUT = ppu_addr_q;
   assign PPU_DATA_OUT = buf_q;
   assign PPU_WREN     = wren_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: source memory returns addr_lo ^ addr_hi ^ 8'h58,
// so page P byte i is expected to be i ^ P ^ 8'h58.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic        CPU_CE;
   logic [15:0] CPU_ADDR = '0;
   logic [7:0]  CPU_DATA_IN = '0;
   logic        CPU_wren = 1'b0;
   logic        CPU_HALT;
   logic [15:0] DMA_BUS_ADDR;
   logic        DMA_BUS_RD;
   logic [7:0]  DMA_BUS_DATA_IN;
   logic [2:0]  PPU_ADDR_OUT;
   logic [7:0]  PPU_DATA_OUT;
   logic        PPU_WREN;
   logic        DMA_ACTIVE;

   int checks = 0;
   int failures = 0;

   int unsigned ce_period = 1;
   int unsigned ce_ph = 0;
   logic        ce_en = 1'b1;

   int          ce_since = 0;
   int          trig_k = 0;
   int          halt_ce, rd_n, wr_n, wr_badaddr, wr_wide;
   logic        wren_prev = 1'b0;
   logic [15:0] rd_log [0:511];
   logic [7:0]  wr_log [0:511];

   oam_dma #(.DMA_REG_ADDR(16'h4014), .OAMDATA_REG(3'h4), .XFER_LEN(256)) dut (
      .CLK(clk), .RESET(RESET), .CPU_CE(CPU_CE), .CPU_ADDR(CPU_ADDR),
      .CPU_DATA_IN(CPU_DATA_IN), .CPU_wren(CPU_wren), .CPU_HALT(CPU_HALT),
      .DMA_BUS_ADDR(DMA_BUS_ADDR), .DMA_BUS_RD(DMA_BUS_RD),
      .DMA_BUS_DATA_IN(DMA_BUS_DATA_IN), .PPU_ADDR_OUT(PPU_ADDR_OUT),
      .PPU_DATA_OUT(PPU_DATA_OUT), .PPU_WREN(PPU_WREN), .DMA_ACTIVE(DMA_ACTIVE)
   );

   assign DMA_BUS_DATA_IN = DMA_BUS_ADDR[7:0] ^ DMA_BUS_ADDR[15:8] ^ 8'h58;

   initial forever #5 clk = ~clk;

   initial begin
      CPU_CE = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         ce_ph = ce_ph + 1;
         CPU_CE = ce_en && ((ce_ph % ce_period) == 0);
      end
   end

   // Negedge sees the inputs the next posedge will act on and the outputs of the current state.
   always @(negedge clk) begin
      if (RESET) ce_since = 0;
      else if (CPU_CE) begin
         ce_since = ce_since + 1;
         if (!DMA_ACTIVE && CPU_wren && CPU_ADDR == 16'h4014) trig_k = ce_since;
      end
      if (CPU_CE && CPU_HALT) halt_ce = halt_ce + 1;
      if (CPU_CE && DMA_BUS_RD) begin
         if (rd_n < 512) rd_log[rd_n] = DMA_BUS_ADDR;
         rd_n = rd_n + 1;
      end
      if (PPU_WREN) begin
         if (wr_n < 512) wr_log[wr_n] = PPU_DATA_OUT;
         if (PPU_ADDR_OUT != 3'h4) wr_badaddr = wr_badaddr + 1;
         if (wren_prev) wr_wide = wr_wide + 1;
         wr_n = wr_n + 1;
      end
      wren_prev = PPU_WREN;
   end

   task automatic clear_logs();
      halt_ce = 0; rd_n = 0; wr_n = 0; wr_badaddr = 0; wr_wide = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #3; RESET = 1'b1;
      repeat (2) @(posedge clk);
      #3; RESET = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit expect_trig);
      int i;
      for (i = 0; i < 100; i++) begin
         @(posedge clk); #3;
         if (CPU_CE) break;
      end
      CPU_ADDR = a; CPU_DATA_IN = d; CPU_wren = 1'b1;
      @(posedge clk); #3;
      CPU_wren = 1'b0; CPU_ADDR = '0;
      if (expect_trig) begin
         checks++;
         if (CPU_HALT !== 1'b1 || DMA_ACTIVE !== 1'b1) begin
            failures++;
            $display("FAIL start_halt: halt=%b active=%b expected 1 1", CPU_HALT, DMA_ACTIVE);
         end
      end
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 5000; i++) begin
         @(posedge clk); #3;
         if (!DMA_ACTIVE) break;
      end
      checks++;
      if (DMA_ACTIVE !== 1'b0) begin
         failures++;
         $display("FAIL done_timeout: DMA_ACTIVE=%b expected 0 within 5000 clk", DMA_ACTIVE);
      end
      repeat (3) @(posedge clk);
      #3;
   endtask

   task automatic check_xfer(input string nm, input logic [7:0] page, input int exp_halt);
      int bad_i;
      logic [7:0] exp_d;
      checks++;
      if (halt_ce != exp_halt) begin
         failures++; $display("FAIL %s halt_ce: got %0d expected %0d", nm, halt_ce, exp_halt);
      end
      checks++;
      if (wr_n != 256) begin
         failures++; $display("FAIL %s wren_count: got %0d expected 256", nm, wr_n);
      end
      checks++;
      if (rd_n != 256) begin
         failures++; $display("FAIL %s rd_count: got %0d expected 256", nm, rd_n);
      end
      checks++;
      if (wr_badaddr != 0) begin
         failures++; $display("FAIL %s ppu_addr: %0d writes not to reg 4", nm, wr_badaddr);
      end
      checks++;
      if (wr_wide != 0) begin
         failures++; $display("FAIL %s wren_width: %0d pulses wider than 1 clk expected 0", nm, wr_wide);
      end
      bad_i = -1;
      for (int i = 0; i < 256 && i < wr_n; i++) begin
         exp_d = 8'(i) ^ page ^ 8'h58;
         if (bad_i < 0 && wr_log[i] !== exp_d) bad_i = i;
      end
      checks++;
      if (bad_i >= 0) begin
         failures++;
         $display("FAIL %s data[%0d]: got %h expected %h", nm, bad_i, wr_log[bad_i],
                  8'(bad_i) ^ page ^ 8'h58);
      end
      bad_i = -1;
      for (int i = 0; i < 256 && i < rd_n; i++)
         if (bad_i < 0 && rd_log[i] !== {page, 8'(i)}) bad_i = i;
      checks++;
      if (bad_i >= 0) begin
         failures++;
         $display("FAIL %s rd_addr[%0d]: got %h expected %h", nm, bad_i, rd_log[bad_i],
                  {page, 8'(bad_i)});
      end
   endtask

   task automatic test_reset();
      ce_period = 1;
      do_reset();
      checks++;
      if (CPU_HALT !== 1'b0 || DMA_ACTIVE !== 1'b0 || DMA_BUS_RD !== 1'b0 || PPU_WREN !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: halt=%b active=%b rd=%b wren=%b expected 0 0 0 0",
                  CPU_HALT, DMA_ACTIVE, DMA_BUS_RD, PPU_WREN);
      end
      checks++;
      if (DMA_BUS_ADDR !== 16'h0000 || PPU_ADDR_OUT !== 3'h0 || PPU_DATA_OUT !== 8'h00) begin
         failures++;
         $display("FAIL reset_data: addr=%h ppu_addr=%h ppu_data=%h expected 0000 0 00",
                  DMA_BUS_ADDR, PPU_ADDR_OUT, PPU_DATA_OUT);
      end
   endtask

   task automatic test_even();
      ce_period = 1;
      do_reset(); clear_logs();
      do_write(16'h4014, 8'h02, 1'b1);
      wait_done();
      check_xfer("even", 8'h02, 513);
   endtask

   task automatic test_odd();
      ce_period = 1;
      do_reset(); clear_logs();
      @(posedge clk);
      do_write(16'h4014, 8'h02, 1'b1);
      wait_done();
      check_xfer("odd", 8'h02, 514);
   endtask

   task automatic test_slow_ce();
      ce_period = 4;
      do_reset(); clear_logs();
      do_write(16'h4014, 8'hFF, 1'b1);
      wait_done();
      check_xfer("slow_ce", 8'hFF, (trig_k % 2 == 1) ? 514 : 513);
      ce_period = 1;
   endtask

   task automatic test_reset_mid();
      int rd_snap, wr_snap, i;
      ce_period = 1;
      do_reset(); clear_logs();
      do_write(16'h4014, 8'h02, 1'b1);
      for (i = 0; i < 2000; i++) begin
         @(posedge clk); #3;
         if (wr_n >= 100) break;
      end
      RESET = 1'b1;
      @(posedge clk); #3;
      checks++;
      if (CPU_HALT !== 1'b0 || DMA_ACTIVE !== 1'b0 || DMA_BUS_RD !== 1'b0 || PPU_WREN !== 1'b0) begin
         failures++;
         $display("FAIL midreset_ctrl: halt=%b active=%b rd=%b wren=%b expected 0 0 0 0",
                  CPU_HALT, DMA_ACTIVE, DMA_BUS_RD, PPU_WREN);
      end
      checks++;
      if (DMA_BUS_ADDR !== 16'h0000 || PPU_DATA_OUT !== 8'h00) begin
         failures++;
         $display("FAIL midreset_data: addr=%h data=%h expected 0000 00", DMA_BUS_ADDR, PPU_DATA_OUT);
      end
      rd_snap = rd_n; wr_snap = wr_n;
      @(posedge clk); #3; RESET = 1'b0;
      repeat (20) @(posedge clk);
      #3;
      checks++;
      if (rd_n != rd_snap || wr_n != wr_snap || wr_n != 100) begin
         failures++;
         $display("FAIL midreset_quiet: rd %0d->%0d wr %0d->%0d expected no change and 100 writes",
                  rd_snap, rd_n, wr_snap, wr_n);
      end
      clear_logs();
      do_write(16'h4014, 8'h02, 1'b1);
      wait_done();
      check_xfer("after_reset", 8'h02, (trig_k % 2 == 1) ? 514 : 513);
   endtask

   task automatic test_ignored_write();
      int i;
      ce_period = 1;
      do_reset(); clear_logs();
      do_write(16'h4014, 8'h02, 1'b1);
      for (i = 0; i < 2000; i++) begin
         @(posedge clk); #3;
         if (wr_n >= 50) break;
      end
      do_write(16'h4014, 8'h03, 1'b0);
      wait_done();
      check_xfer("ignored", 8'h02, 513);
   endtask

   task automatic test_no_trigger();
      ce_period = 1;
      do_reset(); clear_logs();
      do_write(16'h4015, 8'h05, 1'b0);
      do_write(16'h2014, 8'h06, 1'b0);
      ce_en = 1'b0;
      @(posedge clk); #3;
      CPU_ADDR = 16'h4014; CPU_DATA_IN = 8'h07; CPU_wren = 1'b1;
      @(posedge clk); #3;
      CPU_wren = 1'b0; CPU_ADDR = '0;
      ce_en = 1'b1;
      repeat (10) @(posedge clk);
      #3;
      checks++;
      if (halt_ce != 0 || rd_n != 0 || wr_n != 0 || DMA_ACTIVE !== 1'b0) begin
         failures++;
         $display("FAIL no_trigger: halt_ce=%0d rd=%0d wr=%0d active=%b expected 0 0 0 0",
                  halt_ce, rd_n, wr_n, DMA_ACTIVE);
      end
   endtask

   initial begin
      clear_logs();
      test_reset();
      test_even();
      test_odd();
      test_slow_ce();
      test_reset_mid();
      test_ignored_write();
      test_no_trigger();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
